// File: rtl/mram_pkg.sv
// Shared types and constants for the MRAM responder model.
// Holds FSM state encoding, bus widths, error bit indices and lane helpers.
package mram_pkg;

    localparam int MRAM_ADDR_W = 20;
    localparam int MRAM_DATA_W = 16;

    localparam int ERR_CONTENTION  = 0;
    localparam int ERR_ADDR_CHANGE = 1;

    // Legacy numeric encodings kept so existing waveforms/decoders still match
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WR_ACTIVE = 2'd1;
    localparam logic [1:0] ST_RD_WAIT   = 2'd2;
    localparam logic [1:0] ST_RD_DRIVE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        WR_ACTIVE = ST_WR_ACTIVE,
        RD_WAIT   = ST_RD_WAIT,
        RD_DRIVE  = ST_RD_DRIVE
    } mram_state_t;

    // Active-low byte enables -> active-high lane mask {upper, lower}
    function automatic logic [1:0] lane_mask(input logic upper_n, input logic lower_n);
        return {~upper_n, ~lower_n};
    endfunction

    function automatic logic [MRAM_DATA_W-1:0] lane_gate(input logic [MRAM_DATA_W-1:0] word,
                                                         input logic [1:0] mask);
        return word & {{8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/mram_resp_array.sv
// Byte-writable 2^ADDR_W x 16 storage: one synchronous write port, one async read port.
// Contents start at zero and are never cleared by reset.
module mram_resp_array
    import mram_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [1:0]             wmask,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [MRAM_DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0]      raddr,
    output logic [MRAM_DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [MRAM_DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we && wmask[0]) mem[waddr][7:0]  <= wdata[7:0];
        if (we && wmask[1]) mem[waddr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mram_responder.sv
// Behavioural MRAM device responder driven by the controller's strobes on the same clock.
// Optional protocol checking is enabled by defining MRAM_RESP_ERRCHK_EN.
module mram_responder
    import mram_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   chip_en,
    input  logic                   write_en,
    input  logic                   out_en,
    input  logic                   lower_byte_en,
    input  logic                   upper_byte_en,
    input  logic [MRAM_ADDR_W-1:0] mram_addr,
    input  logic [MRAM_DATA_W-1:0] mram_dq_in,
    output logic [MRAM_DATA_W-1:0] mram_dq_out,
    output logic                   mram_dq_oe,
    output logic                   wr_done,
    output logic                   rd_done,
    input  logic                   err_clr,
    output logic [1:0]             err
);

    logic                   wr_act;
    logic                   rd_act;
    logic                   commit;
    mram_state_t            state;
    mram_state_t            state_nxt;
    logic [MRAM_ADDR_W-1:0] lat_addr;
    logic [MRAM_DATA_W-1:0] lat_data;
    logic [1:0]             lat_mask;
    logic [MRAM_DATA_W-1:0] arr_rdata;
    logic [MRAM_DATA_W-1:0] rd_word;

    assign wr_act = ~chip_en & ~write_en;
    assign rd_act = ~chip_en & write_en & ~out_en;
    assign commit = (state == WR_ACTIVE) & ~wr_act;

    assign rd_word = lane_gate(arr_rdata, lane_mask(upper_byte_en, lower_byte_en));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (wr_act)
                    state_nxt = WR_ACTIVE;
                else if (rd_act)
                    state_nxt = (READ_LAT == 2) ? RD_WAIT : RD_DRIVE;
            end
            WR_ACTIVE: if (!wr_act) state_nxt = IDLE;
            RD_WAIT:   state_nxt = rd_act ? RD_DRIVE : IDLE;
            RD_DRIVE:  if (!rd_act) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Output drive follows the next state, so data appears on the entering edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_mask    <= '0;
            mram_dq_out <= '0;
            mram_dq_oe  <= 1'b0;
            wr_done     <= 1'b0;
            rd_done     <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_done <= commit & (|lat_mask);
            rd_done <= (state == RD_DRIVE) & ~rd_act;
            if (wr_act && (state == IDLE || state == WR_ACTIVE)) begin
                lat_addr <= mram_addr;
                lat_data <= mram_dq_in;
                lat_mask <= lane_mask(upper_byte_en, lower_byte_en);
            end
            if (state_nxt == RD_DRIVE) begin
                mram_dq_oe  <= 1'b1;
                mram_dq_out <= rd_word;
            end else begin
                mram_dq_oe  <= 1'b0;
                mram_dq_out <= '0;
            end
        end
    end

    mram_resp_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (commit),
        .wmask(lat_mask),
        .waddr(lat_addr[ADDR_W-1:0]),
        .wdata(lat_data),
        .raddr(mram_addr[ADDR_W-1:0]),
        .rdata(arr_rdata)
    );

`ifdef MRAM_RESP_ERRCHK_EN
    logic [1:0] err_q;
    logic [1:0] err_set;

    always_comb begin
        err_set                  = '0;
        err_set[ERR_CONTENTION]  = ~chip_en & ~write_en & ~out_en;
        err_set[ERR_ADDR_CHANGE] = (state == WR_ACTIVE) && (mram_addr != lat_addr);
    end

    // A set arriving with a clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else
            err_q <= (err_clr ? 2'b00 : err_q) | err_set;
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

    // Upper address bits alias away; err_clr only matters with checking enabled
    logic unused_bits;
    assign unused_bits = ^{mram_addr, lat_addr, err_clr};

endmodule

// File: doc/mram_responder.md
MRAM_RESPONDER -- requirements
Module: mram_responder

Interface
REQ-001 Parameter ADDR_W, default 8: internal array holds 2^ADDR_W words; only the low ADDR_W bits of the address are used.
REQ-002 Parameter READ_LAT, default 1, legal 1..2: number of clock edges from read-active to data driven.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 chip_en  input  1  MRAM chip enable, active low.
REQ-006 write_en  input  1  write enable, active low.
REQ-007 out_en  input  1  output enable, active low.
REQ-008 lower_byte_en  input  1  byte lane [7:0] enable, active low.
REQ-009 upper_byte_en  input  1  byte lane [15:8] enable, active low.
REQ-010 mram_addr  input  20  word address from the controller's address shift register.
REQ-011 mram_dq_in  input  16  write data from the controller.
REQ-012 mram_dq_out  output  16  read data, registered.
REQ-013 mram_dq_oe  output  1  high while the responder drives mram_dq_out.
REQ-014 wr_done  output  1  one-cycle pulse per committed write.
REQ-015 rd_done  output  1  one-cycle pulse at the end of each driven read.
REQ-016 err_clr  input  1  clears sticky error flags.
REQ-017 err  output  2  sticky protocol-error flags: [0] contention, [1] address change during write.

Function
REQ-018 wr_act = ~chip_en & ~write_en; rd_act = ~chip_en & write_en & ~out_en; all strobes are sampled on clk, with no synchronizers (same clock domain as the controller).
REQ-019 FSM states are IDLE, WR_ACTIVE, RD_WAIT and RD_DRIVE.
REQ-020 IDLE transitions: to WR_ACTIVE on wr_act; otherwise to RD_WAIT on rd_act when READ_LAT=2, or to RD_DRIVE when READ_LAT=1.
REQ-021 wr_act has priority over rd_act; with chip_en, write_en and out_en all low, mram_dq_oe SHALL stay 0.
REQ-022 In WR_ACTIVE, addr, data and lane enables are latched every cycle; the last latched values are used at commit.
REQ-023 A write commits on the first edge sampling wr_act=0 (enable-controlled or WE-controlled end); the FSM returns to IDLE and wr_done pulses.
REQ-024 A write with both lane enables high at commit updates no memory and does not pulse wr_done.
REQ-025 A lane whose enable is low at commit writes its byte; the other byte is preserved.
REQ-026 RD_WAIT goes to RD_DRIVE on the next edge if rd_act is still 1, else to IDLE without pulsing rd_done.
REQ-027 In RD_DRIVE: mram_dq_oe=1; mram_dq_out = mem[addr] re-registered each cycle; a disabled lane reads 0x00.
REQ-028 RD_DRIVE exits on the first edge sampling rd_act=0: mram_dq_oe falls on that edge, mram_dq_out returns to 0, and rd_done pulses.
REQ-029 A transition from rd_act directly to wr_act passes through IDLE for one cycle.
REQ-030 Address bits [19:ADDR_W] are ignored, so addresses alias modulo 2^ADDR_W.

Reset
REQ-031 On rst: FSM=IDLE; mram_dq_out=0; mram_dq_oe=0; wr_done=0; rd_done=0; err=0; latched addr/data=0.
REQ-032 rst asserted during WR_ACTIVE aborts the write with no commit.
REQ-033 Array contents are not cleared by rst; the array initializes to 0 at configuration.

Configuration
REQ-034 With MRAM_RESP_ERRCHK_EN defined: err[0] sets on any edge sampling chip_en, write_en and out_en all low; err[1] sets when mram_addr differs from the latched address while in WR_ACTIVE.
REQ-035 With MRAM_RESP_ERRCHK_EN defined: err_clr clears err, and a set and a clear in the same cycle resolve to set.
REQ-036 Without MRAM_RESP_ERRCHK_EN: err is tied to 0, err_clr is ignored, and no checking logic is present.

Structure
REQ-037 Package mram_pkg holds the FSM state enum, MRAM_ADDR_W=20, MRAM_DATA_W=16, and the error bit index constants.
REQ-038 Sub-module mram_resp_array holds the byte-writable 2^ADDR_W x 16 storage with one write port, one read port and a 2-bit lane mask.

Verification
REQ-039 Full write: addr=0x00012, data=0xBEEF, both lanes low for 2 cycles, then chip_en high -> wr_done pulses once; mem[0x12]=0xBEEF.
REQ-040 Lower-byte write: data=0x1234 with only lower_byte_en low to addr 0x12 holding 0xBEEF -> mem[0x12]=0xBE34.
REQ-041 Read with READ_LAT=1: addr 0x12 with chip_en and out_en low for 2 cycles, both lanes low -> mram_dq_oe high 2 cycles, mram_dq_out=0xBE34; upper-lane-only read returns 0xBE00; rd_done pulses once after exit.
REQ-042 Aliasing: write 0xA5A5 to 0xFFF05 -> read of 0x00005 returns 0xA5A5.
REQ-043 Abort: rst pulsed while in WR_ACTIVE writing 0x5555 to 0x20 -> mem[0x20] unchanged, wr_done stays 0.
REQ-044 With MRAM_RESP_ERRCHK_EN: all three strobes low for 1 cycle -> err=2'b01, no drive, write commits; err_clr -> err=0.
